// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM command-bus arbiter.
//   - arbiter state encoding (also exported on the arb_state debug port)
//   - SDRAM command encodings {CS_n,RAS_n,CAS_n,WE_n}
//   - default pin widths
package sdram_pkg;

  localparam int ADDR_BITS = 12;
  localparam int BA_BITS   = 2;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } arb_state_e;

  // Which read/write source won the most recent grant.
  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } last_rw_e;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  function automatic logic is_busy(arb_state_e s);
    return (s == S_AREF) || (s == S_WRITE) || (s == S_READ);
  endfunction

endpackage

// File: rtl/sdram_arb_wdog.sv
// sdram_arb_wdog: busy-time watchdog for the arbiter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : a grant is being issued this cycle (clears the counter)
//   busy_i        : arbiter is in a busy state this cycle
//   done_i        : the granted source signalled completion this cycle
//   expire_o      : this is the MAX_BUSY-th busy cycle of the operation
//   err_o         : sticky, set when an operation expired without done
module sdram_arb_wdog #(
  parameter int MAX_BUSY = 64,
  parameter int WD_BITS  = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic busy_i,
  input  logic done_i,
  output logic expire_o,
  output logic err_o
);
  import sdram_pkg::*;

  // cnt_q is 0 in the first busy cycle, so cnt_q == MAX_BUSY-1 marks the
  // last cycle an operation may hold the bus.
  logic [WD_BITS-1:0] cnt_q;
  logic               err_q;

  assign expire_o = busy_i && (cnt_q == WD_BITS'(MAX_BUSY - 1));
  assign err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_i)
        cnt_q <= '0;
      else if (busy_i && !expire_o)
        cnt_q <= cnt_q + 1'b1;
      // A done landing on the expiry cycle is an ordinary completion.
      if (expire_o && !done_i)
        err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM command bus. Holds it for the init sequencer
// until init_done, then grants it to auto-refresh (highest priority), write or
// read, alternating write/read when both are pending.
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   init_*                      : init sequencer command/address, init_done
//   aref_* / wr_* / rd_*        : requester req (level), done (pulse), cmd/ba/addr
//   aref_en / wr_en / rd_en     : registered 1-cycle grant pulses
//   sdram_cmd/ba/addr           : muxed pin outputs
//   arb_state                   : current state (debug)
//   wd_err                      : sticky watchdog error
module sdram_arbiter #(
  parameter int ADDR_BITS = sdram_pkg::ADDR_BITS,
  parameter int BA_BITS   = sdram_pkg::BA_BITS,
  parameter int MAX_BUSY  = 64,
  parameter int WD_BITS   = 7
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 init_done,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  input  logic                 aref_done,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 wr_req,
  input  logic                 wr_done,
  input  logic [3:0]           wr_cmd,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic                 rd_req,
  input  logic                 rd_done,
  input  logic [3:0]           rd_cmd,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 aref_en,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [3:0]           sdram_cmd,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [2:0]           arb_state,
  output logic                 wd_err
);
  import sdram_pkg::*;

  arb_state_e state_q;
  arb_state_e grant_d;
  last_rw_e   last_rw_q;
  logic       aref_en_q, wr_en_q, rd_en_q;
  logic       done_sel;
  logic       wd_start, wd_expire;

  // Winner if the arbiter is idle this cycle; S_IDLE means nobody.
  // last_rw tracks every read/write grant, so when both are pending the one
  // that did not go most recently wins.
  always_comb begin
    grant_d = S_IDLE;
    if (aref_req)
      grant_d = S_AREF;
    else if (wr_req && (!rd_req || last_rw_q == LAST_RD))
      grant_d = S_WRITE;
    else if (rd_req)
      grant_d = S_READ;
  end

  // Only the granted source's done counts; the others are ignored.
  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      S_AREF:  done_sel = aref_done;
      S_WRITE: done_sel = wr_done;
      S_READ:  done_sel = rd_done;
      default: done_sel = 1'b0;
    endcase
  end

  assign wd_start = (state_q == S_IDLE) && (grant_d != S_IDLE);

  sdram_arb_wdog #(
    .MAX_BUSY (MAX_BUSY),
    .WD_BITS  (WD_BITS)
  ) u_wdog (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .start_i  (wd_start),
    .busy_i   (is_busy(state_q)),
    .done_i   (done_sel),
    .expire_o (wd_expire),
    .err_o    (wd_err)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_INIT;
      last_rw_q <= LAST_RD;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      case (state_q)
        S_INIT: if (init_done) state_q <= S_IDLE;
        S_IDLE: begin
          state_q   <= grant_d;
          aref_en_q <= (grant_d == S_AREF);
          wr_en_q   <= (grant_d == S_WRITE);
          rd_en_q   <= (grant_d == S_READ);
          if (grant_d == S_WRITE) last_rw_q <= LAST_WR;
          if (grant_d == S_READ)  last_rw_q <= LAST_RD;
        end
        S_AREF, S_WRITE, S_READ:
          if (done_sel || wd_expire) state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  localparam int AB   = 12;
  localparam int BB   = 2;
  localparam int MAXB = 64;
  localparam int ST_INIT = 0, ST_IDLE = 1, ST_AREF = 2, ST_WR = 3, ST_RD = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic [3:0]    init_cmd = 4'hA;
  logic [AB-1:0] init_addr = '0;
  logic          aref_req = 1'b0, aref_done = 1'b0;
  logic [3:0]    aref_cmd = 4'h1;
  logic [AB-1:0] aref_addr = '0;
  logic          wr_req = 1'b0, wr_done = 1'b0;
  logic [3:0]    wr_cmd = 4'h4;
  logic [BB-1:0] wr_ba = '0;
  logic [AB-1:0] wr_addr = '0;
  logic          rd_req = 1'b0, rd_done = 1'b0;
  logic [3:0]    rd_cmd = 4'h5;
  logic [BB-1:0] rd_ba = '0;
  logic [AB-1:0] rd_addr = '0;
  logic          aref_en, wr_en, rd_en, wd_err;
  logic [3:0]    sdram_cmd;
  logic [BB-1:0] sdram_ba;
  logic [AB-1:0] sdram_addr;
  logic [2:0]    arb_state;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ADDR_BITS(AB), .BA_BITS(BB), .MAX_BUSY(MAXB), .WD_BITS(7)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_done(aref_done), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_done(wr_done), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .arb_state(arb_state), .wd_err(wd_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural reference: who owns the bus, how many busy cycles it has used,
  // which of read/write went last, and what the grant pulses should be.
  int m_state = ST_INIT;
  int m_used  = 0;
  bit m_last_wr = 1'b0;
  bit m_err = 1'b0;
  bit m_aen = 1'b0, m_wen = 1'b0, m_ren = 1'b0;

  task automatic model_step();
    bit done;
    m_aen = 1'b0; m_wen = 1'b0; m_ren = 1'b0;
    if (!sys_rst_n) begin
      m_state = ST_INIT; m_used = 0; m_last_wr = 1'b0; m_err = 1'b0;
    end else if (m_state == ST_INIT) begin
      if (init_done) m_state = ST_IDLE;
    end else if (m_state == ST_IDLE) begin
      if (aref_req) begin
        m_state = ST_AREF; m_aen = 1'b1; m_used = 0;
      end else if (wr_req && (!rd_req || !m_last_wr)) begin
        m_state = ST_WR; m_wen = 1'b1; m_used = 0; m_last_wr = 1'b1;
      end else if (rd_req) begin
        m_state = ST_RD; m_ren = 1'b1; m_used = 0; m_last_wr = 1'b0;
      end
    end else begin
      done = (m_state == ST_AREF) ? aref_done : (m_state == ST_WR) ? wr_done : rd_done;
      m_used++;
      if (done) m_state = ST_IDLE;
      else if (m_used == MAXB) begin m_state = ST_IDLE; m_err = 1'b1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_init();
    sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1;
    init_done = 1'b1; tick(); init_done = 1'b0;
  endtask

  task automatic test_reset();
    init_addr = 12'h5A5; aref_addr = 12'h0F0; wr_addr = 12'h123; rd_addr = 12'h321;
    wr_ba = 2'd2; rd_ba = 2'd3;
    sys_rst_n = 1'b0; tick(); tick();
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", arb_state); end
    checks++; if ({aref_en, wr_en, rd_en} !== 3'b000) begin errors++; $display("FAIL reset_en got %b want 000", {aref_en, wr_en, rd_en}); end
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL reset_wderr got %b want 0", wd_err); end
    checks++; if (sdram_cmd !== 4'hA || sdram_addr !== 12'h5A5 || sdram_ba !== 2'd0) begin errors++;
      $display("FAIL reset_pins got %h/%h/%h want a/0/5a5", sdram_cmd, sdram_ba, sdram_addr); end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (arb_state !== 3'd0 || sdram_cmd !== 4'hA) begin errors++;
        $display("FAIL init_hold cyc %0d got st %0d cmd %h want 0/a", i, arb_state, sdram_cmd); end
    end
    init_done = 1'b1; tick(); init_done = 1'b0;
    checks++; if (arb_state !== 3'd1 || sdram_cmd !== 4'b0111 || sdram_addr !== 12'h0 || sdram_ba !== 2'd0) begin errors++;
      $display("FAIL init_to_idle got st %0d cmd %h addr %h want 1/7/0", arb_state, sdram_cmd, sdram_addr); end
  endtask

  task automatic test_aref_priority();
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; tick();
    checks++; if (arb_state !== 3'd2 || {aref_en, wr_en, rd_en} !== 3'b100) begin errors++;
      $display("FAIL aref_grant got st %0d en %b want 2/100", arb_state, {aref_en, wr_en, rd_en}); end
    checks++; if (sdram_cmd !== 4'h1 || sdram_addr !== 12'h0F0 || sdram_ba !== 2'd0) begin errors++;
      $display("FAIL aref_pins got %h/%h/%h want 1/0/0f0", sdram_cmd, sdram_ba, sdram_addr); end
    aref_req = 1'b0; tick();
    checks++; if (aref_en !== 1'b0 || arb_state !== 3'd2) begin errors++;
      $display("FAIL aref_pulse_width got en %b st %0d want 0/2", aref_en, arb_state); end
    aref_done = 1'b1; tick(); aref_done = 1'b0;
    checks++; if (arb_state !== 3'd1 || sdram_cmd !== 4'b0111) begin errors++;
      $display("FAIL aref_return got st %0d cmd %h want 1/7", arb_state, sdram_cmd); end
    tick();
    checks++; if (arb_state !== 3'd3 || {aref_en, wr_en, rd_en} !== 3'b010) begin errors++;
      $display("FAIL wr_after_aref got st %0d en %b want 3/010", arb_state, {aref_en, wr_en, rd_en}); end
    checks++; if (sdram_cmd !== 4'h4 || sdram_ba !== 2'd2 || sdram_addr !== 12'h123) begin errors++;
      $display("FAIL wr_pins got %h/%h/%h want 4/2/123", sdram_cmd, sdram_ba, sdram_addr); end
    wr_req = 1'b0; wr_done = 1'b1; tick(); wr_done = 1'b0;
    tick();
    checks++; if (arb_state !== 3'd4 || rd_en !== 1'b1 || sdram_cmd !== 4'h5 || sdram_ba !== 2'd3 || sdram_addr !== 12'h321) begin errors++;
      $display("FAIL rd_after_wr got st %0d en %b cmd %h want 4/1/5", arb_state, rd_en, sdram_cmd); end
    rd_req = 1'b0; rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  task automatic test_alternate();
    bit exp_wr = 1'b1;
    int waited;
    bit timeout = 1'b0;
    do_init();
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 8 && !timeout; g++) begin
      waited = 0;
      do begin tick(); waited++; end while (!(wr_en || rd_en) && waited < 10);
      checks++;
      if (!(wr_en || rd_en)) begin errors++; timeout = 1'b1;
        $display("FAIL alt_grant_timeout grant %0d got none want en", g); end
      else if ({wr_en, rd_en} !== (exp_wr ? 2'b10 : 2'b01) || waited != 1) begin errors++;
        $display("FAIL alt_order grant %0d got wr/rd %b after %0d want %b after 1", g, {wr_en, rd_en}, waited, exp_wr ? 2'b10 : 2'b01); end
      if (!timeout) begin
        for (int k = 1; k <= 5; k++) begin
          tick();
          checks++; if ({wr_en, rd_en} !== 2'b00 || arb_state !== (exp_wr ? 3'd3 : 3'd4)) begin errors++;
            $display("FAIL alt_busy grant %0d cyc %0d got en %b st %0d", g, k, {wr_en, rd_en}, arb_state); end
        end
        if (exp_wr) wr_done = 1'b1; else rd_done = 1'b1;
        tick(); wr_done = 1'b0; rd_done = 1'b0;
        checks++; if (arb_state !== 3'd1 || sdram_cmd !== 4'b0111 || {wr_en, rd_en} !== 2'b00) begin errors++;
          $display("FAIL alt_nop grant %0d got st %0d cmd %h want 1/7", g, arb_state, sdram_cmd); end
        exp_wr = !exp_wr;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
  endtask

  task automatic test_no_preempt();
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    checks++; if (arb_state !== 3'd3 || wr_en !== 1'b1) begin errors++;
      $display("FAIL np_wr_grant got st %0d en %b want 3/1", arb_state, wr_en); end
    aref_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (arb_state !== 3'd3 || aref_en !== 1'b0) begin errors++;
        $display("FAIL np_hold cyc %0d got st %0d aref_en %b want 3/0", k, arb_state, aref_en); end
    end
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    checks++; if (arb_state !== 3'd1 || aref_en !== 1'b0) begin errors++;
      $display("FAIL np_idle got st %0d aref_en %b want 1/0", arb_state, aref_en); end
    tick();
    checks++; if (arb_state !== 3'd2 || aref_en !== 1'b1) begin errors++;
      $display("FAIL np_aref got st %0d aref_en %b want 2/1", arb_state, aref_en); end
    aref_req = 1'b0; aref_done = 1'b1; tick(); aref_done = 1'b0;
  endtask

  task automatic test_spurious_done();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    wr_done = 1'b1; aref_done = 1'b1; tick(); wr_done = 1'b0; aref_done = 1'b0;
    checks++; if (arb_state !== 3'd4) begin errors++;
      $display("FAIL spurious_done got st %0d want 4", arb_state); end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    checks++; if (arb_state !== 3'd1) begin errors++;
      $display("FAIL spurious_return got st %0d want 1", arb_state); end
  endtask

  task automatic test_watchdog();
    int bad = 0;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    // Now in busy cycle 1; the read may occupy cycles 1..MAXB.
    for (int c = 2; c <= MAXB; c++) begin
      tick();
      if (arb_state !== 3'd4 || wd_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL wd_hold got %0d bad cycles want 0", bad); end
    tick();
    checks++; if (arb_state !== 3'd1 || wd_err !== 1'b1) begin errors++;
      $display("FAIL wd_expire got st %0d err %b want 1/1", arb_state, wd_err); end
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    checks++; if (arb_state !== 3'd3 || wd_err !== 1'b1) begin errors++;
      $display("FAIL wd_sticky got st %0d err %b want 3/1", arb_state, wd_err); end
  endtask

  task automatic test_reset_mid();
    tick();
    sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1;
    checks++; if (arb_state !== 3'd0 || wr_en !== 1'b0 || wd_err !== 1'b0 || sdram_cmd !== init_cmd) begin errors++;
      $display("FAIL reset_mid got st %0d wr_en %b err %b cmd %h want 0/0/0/%h", arb_state, wr_en, wd_err, sdram_cmd, init_cmd); end
  endtask

  task automatic test_wd_done_at_expiry();
    do_init();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    for (int c = 2; c <= MAXB; c++) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    checks++; if (arb_state !== 3'd1 || wd_err !== 1'b0) begin errors++;
      $display("FAIL wd_done_expiry got st %0d err %b want 1/0", arb_state, wd_err); end
    tick();
  endtask

  task automatic test_random();
    bit rq[3], dn[3], act[3], ens[3];
    int cd[3];
    logic [3:0]    ec;
    logic [BB-1:0] eb;
    logic [AB-1:0] ea;
    for (int i = 0; i < 3; i++) begin rq[i] = 0; dn[i] = 0; act[i] = 0; cd[i] = 0; end
    aref_req = 0; wr_req = 0; rd_req = 0; aref_done = 0; wr_done = 0; rd_done = 0;
    do_init();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_addr = AB'($urandom); aref_addr = AB'($urandom); wr_addr = AB'($urandom); rd_addr = AB'($urandom);
      wr_ba = BB'($urandom); rd_ba = BB'($urandom);
      aref_req = rq[0]; wr_req = rq[1]; rd_req = rq[2];
      aref_done = dn[0]; wr_done = dn[1]; rd_done = dn[2];
      tick();
      case (m_state)
        ST_INIT: begin ec = init_cmd; eb = '0;    ea = init_addr; end
        ST_AREF: begin ec = aref_cmd; eb = '0;    ea = aref_addr; end
        ST_WR:   begin ec = wr_cmd;   eb = wr_ba; ea = wr_addr;   end
        ST_RD:   begin ec = rd_cmd;   eb = rd_ba; ea = rd_addr;   end
        default: begin ec = 4'b0111;  eb = '0;    ea = '0;        end
      endcase
      checks++; if (arb_state !== 3'(m_state) || {aref_en, wr_en, rd_en} !== {m_aen, m_wen, m_ren} || wd_err !== m_err) begin errors++;
        $display("FAIL rand_ctrl cyc %0d got st %0d en %b err %b want %0d/%b/%b", cyc, arb_state,
                 {aref_en, wr_en, rd_en}, wd_err, m_state, {m_aen, m_wen, m_ren}, m_err); end
      checks++; if (sdram_cmd !== ec || sdram_ba !== eb || sdram_addr !== ea) begin errors++;
        $display("FAIL rand_pins cyc %0d got %h/%h/%h want %h/%h/%h", cyc, sdram_cmd, sdram_ba, sdram_addr, ec, eb, ea); end
      ens[0] = aref_en; ens[1] = wr_en; ens[2] = rd_en;
      for (int i = 0; i < 3; i++) begin
        dn[i] = 1'b0;
        if (act[i]) begin
          cd[i]--;
          if (cd[i] == 0) begin dn[i] = 1'b1; act[i] = 1'b0; end
        end else if (ens[i]) begin
          rq[i] = 1'b0; act[i] = 1'b1; cd[i] = $urandom_range(1, 6);
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
        end
      end
    end
    aref_req = 0; wr_req = 0; rd_req = 0; aref_done = 0; wr_done = 0; rd_done = 0;
  endtask

  initial begin
    test_reset();
    test_aref_priority();
    test_alternate();
    test_no_preempt();
    test_spurious_done();
    test_watchdog();
    test_reset_mid();
    test_wd_done_at_expiry();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
